bank_skew_loader: RTL and testbench
===================================

# bank_skew_loader

Front-end buffer for the privacy-amplification FFT datapath. It accepts a serial stream of 64-bit key/seed words and writes them into 16 parallel memory banks using a skewed, conflict-free mapping. It then reads one 16-word chunk per cycle across all banks. It drives the bank-ordered data, per-lane bank numbers, chunk cycle count and `fft_enable` that `permutation_module` consumes directly downstream.

## Interface
- `DATA_WIDTH`, 64: word width.
- `BANK_COUNT`, 16: number of banks. Fixed at 16; the bank index is 4 bits.
- `DEPTH`, 256: words per bank. Total block size N = BANK_COUNT*DEPTH = 4096.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle request to begin a load. Honoured only in IDLE.
- `in_data` in 64: serial input word.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts a word this cycle. High only in LOAD.
- `stall` in 1: downstream hold. While high, no read is issued.
- `data_out` out 16*64: bank b occupies bits [b*64 +: 64].
- `bank_num` out 16*4: lane k occupies bits [k*4 +: 4]. It is the bank holding chunk word k.
- `cycle_count` out 12: index c of the chunk on `data_out`.
- `fft_enable` out 1: `data_out`, `bank_num` and `cycle_count` are valid this cycle.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last chunk has been presented.

## Operation
- States:
  - IDLE → LOAD when `start`=1.
  - LOAD → READ when the N-th word is accepted.
  - READ → FLUSH when the read of chunk DEPTH-1 is issued.
  - FLUSH → IDLE after one cycle. `done`=1 during FLUSH.
- LOAD:
  - A word is accepted when `in_valid && in_ready`.
  - The write index i counts 0..N-1.
  - Word i goes to bank (i + (i>>4)) mod 16, address i>>4.
  - Cycles with `in_valid`=0 insert gaps with no side effect.
  - `start` is ignored outside IDLE.
- READ:
  - The read counter c counts 0..DEPTH-1.
  - Each non-stalled cycle, every bank is read at address c, then c increments.
  - Chunk c word k lives in bank (k+c) mod 16, so `bank_num[k]` = (k+c) mod 16.
  - `data_out` bank b therefore holds word 16c + ((b−c) mod 16).
- Arithmetic:
  - All bank and lane sums are 4-bit, wrapping modulo 16.
  - c is 8 bits internally and zero-extended to the 12-bit `cycle_count`.
- Banks: one write port and one read port each, 1-cycle synchronous read latency. There is no read/write overlap, because LOAD and READ are exclusive.
- Reset mid-operation:
  - Returns to IDLE immediately and clears all counters.
  - Bank contents are not cleared and are unspecified after reset.
- `stall` outside READ has no effect.

## Timing
- Reset values:
  - `in_ready`=0, `fft_enable`=0, `busy`=0, `done`=0.
  - `data_out`=0, `bank_num`=0, `cycle_count`=0.
  - State IDLE.
- `start` sampled at edge t: LOAD from t+1, so `in_ready`=1 in that cycle.
- Load length: N accepted words. The minimum is N cycles, with no backpressure from the block.
- The last word accepted at edge t puts the block in READ at t+1. The first read is issued in that cycle.
- Read latency: a read issued in cycle t (READ && !`stall`) gives `fft_enable`=1 in cycle t+1, with data, `bank_num` and `cycle_count` aligned.
- `stall`=1 in cycle t:
  - No read is issued and c holds.
  - `fft_enable`=0 at t+1.
  - The output registers hold their values.
- `stall` asserted in the cycle the last read would issue delays FLUSH until the read is issued.
- Unstalled READ takes DEPTH cycles. `fft_enable` is high for exactly DEPTH cycles per block.
- `done` coincides with the `fft_enable` of chunk DEPTH-1, in FLUSH.
- `start` may be asserted in the cycle after FLUSH. Back-to-back blocks have no other idle requirement.

## Configuration
- `BANK_SKEW_EN` defined: the skewed mapping above applies.
- `BANK_SKEW_EN` undefined:
  - Word i goes to bank i mod 16, address i>>4.
  - `bank_num[k]` = k constant and `data_out` bank b holds word 16c+b.
  - `cycle_count` and all timing are unchanged.

## Test plan
- Reset check: assert `rst_n`=0 during READ at c=10 → next cycle all outputs are 0 and the state is IDLE. `start` then reloads correctly.
- Full load with no gaps, word i = i, skew enabled:
  - Chunk 1: bank 0 = 31, bank 1 = 16, `bank_num[0]`=1, `cycle_count`=1.
  - Chunk 255: bank 15 = 4080.
  - `fft_enable` high for 256 cycles.
- Load with `in_valid` toggling every other cycle → same contents. The load takes 8191 cycles.
- `stall` high for 3 cycles at c=5:
  - `fft_enable` low for 3 cycles and outputs hold chunk 4.
  - Chunk 5 follows without loss or duplication.
- `done` pulses once, aligned with `cycle_count`=255.
- Back-to-back blocks: `start` in the cycle after FLUSH → `in_ready`=1 the next cycle.
- Build without `BANK_SKEW_EN`: chunk 1 bank 0 = 16, `bank_num` = {15,...,1,0} constant.

Source files
------------

// File: rtl/bank_skew_loader.sv
// Serial-to-banked loader feeding the FFT permutation stage: fills 16 banks, then streams one
// chunk per cycle. Define BANK_SKEW_EN for the conflict-free skewed bank mapping.
module bank_skew_loader #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned BankCount = 16,
  parameter int unsigned Depth     = 256,
  localparam int unsigned BankW    = $clog2(BankCount),
  localparam int unsigned AddrW    = $clog2(Depth),
  localparam int unsigned CountW   = $clog2(BankCount * Depth)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [DataWidth-1:0]           in_data_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic                           stall_i,
  output logic [BankCount*DataWidth-1:0] data_out_o,
  output logic [BankCount*BankW-1:0]     bank_num_o,
  output logic [CountW-1:0]              cycle_count_o,
  output logic                           fft_enable_o,
  output logic                           busy_o,
  output logic                           done_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StRead, StFlush} state_e;

  state_e state_q, state_d;

  logic [CountW-1:0] wr_idx_q, wr_idx_d;
  logic [AddrW-1:0]  rd_idx_q, rd_idx_d;
  logic              wr_en, rd_en, last_wr, last_rd;
  logic [BankW-1:0]  wr_bank;
  logic [AddrW-1:0]  wr_addr;

  logic [DataWidth-1:0] mem [BankCount][Depth];

  logic [BankCount-1:0][DataWidth-1:0] data_q;
  logic [BankCount-1:0][BankW-1:0]     bank_num_q, bank_num_d;
  logic [CountW-1:0]                   cycle_count_q;
  logic                                fft_enable_q;

  assign last_wr = (wr_idx_q == CountW'(BankCount * Depth - 1));
  assign last_rd = (rd_idx_q == AddrW'(Depth - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLoad;
      StLoad:  if (wr_en && last_wr) state_d = StRead;
      StRead:  if (rd_en && last_rd) state_d = StFlush;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == StLoad);
    busy_o     = (state_q != StIdle);
    done_o     = (state_q == StFlush);
    wr_en      = (state_q == StLoad) && in_valid_i;
    rd_en      = (state_q == StRead) && !stall_i;
  end

  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    if (state_q == StIdle) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
    end
    if (wr_en) wr_idx_d = wr_idx_q + 1'b1;
    if (rd_en) rd_idx_d = rd_idx_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Row = i>>4; the skew rotates each row by its own index so every chunk spans all banks.
  assign wr_addr = wr_idx_q[BankW +: AddrW];
`ifdef BANK_SKEW_EN
  assign wr_bank = wr_idx_q[BankW-1:0] + wr_idx_q[BankW +: BankW];
`else
  assign wr_bank = wr_idx_q[BankW-1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_bank][wr_addr] <= in_data_i;
  end

  always_comb begin
    bank_num_d = '0;
    for (int unsigned k = 0; k < BankCount; k++) begin
`ifdef BANK_SKEW_EN
      bank_num_d[k] = BankW'(k) + rd_idx_q[BankW-1:0];
`else
      bank_num_d[k] = BankW'(k);
`endif
    end
  end

  // Read data register doubles as the output register, so it holds through stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q        <= '0;
      bank_num_q    <= '0;
      cycle_count_q <= '0;
      fft_enable_q  <= 1'b0;
    end else begin
      fft_enable_q <= rd_en;
      if (rd_en) begin
        for (int unsigned b = 0; b < BankCount; b++) begin
          data_q[b] <= mem[b][rd_idx_q];
        end
        bank_num_q    <= bank_num_d;
        cycle_count_q <= CountW'(rd_idx_q);
      end
    end
  end

  assign data_out_o    = data_q;
  assign bank_num_o    = bank_num_q;
  assign cycle_count_o = cycle_count_q;
  assign fft_enable_o  = fft_enable_q;

endmodule

// File: tb/tb_bank_skew_loader.sv
// Scoreboard bench for bank_skew_loader: expected chunks queued per block, popped by a monitor.
module tb_bank_skew_loader;

  localparam int N = 4096;
  localparam int D = 256;
  localparam int B = 16;
`ifdef BANK_SKEW_EN
  localparam bit Skew = 1'b1;
`else
  localparam bit Skew = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          stall;
  logic [1023:0] data_out;
  logic [63:0]   bank_num;
  logic [11:0]   cycle_count;
  logic          fft_enable;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  bank_skew_loader dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .in_data_i     (in_data),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .stall_i       (stall),
    .data_out_o    (data_out),
    .bank_num_o    (bank_num),
    .cycle_count_o (cycle_count),
    .fft_enable_o  (fft_enable),
    .busy_o        (busy),
    .done_o        (done)
  );

  typedef struct {
    logic [1023:0] data;
    logic [63:0]   bn;
    logic [11:0]   cc;
  } chunk_t;

  chunk_t      sb[$];
  chunk_t      last_exp;
  logic [63:0] words[N];
  int          vectors = 0;
  int          miscompares = 0;
  int          fe_cnt = 0;
  int          done_cnt = 0;
  int          stall_mode = 0;
  bit          stall_fired = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: chunk c is words 16c..16c+15; bank b carries the word whose lane k satisfies
  // bank(k) == b, i.e. k = (b - c) mod 16 when skewed, k = b otherwise.
  function automatic chunk_t model(input int c);
    chunk_t r;
    int     lane;
    for (int b = 0; b < B; b++) begin
      lane = Skew ? (((b - c) % B) + B) % B : b;
      r.data[b*64 +: 64] = words[B * c + lane];
      r.bn[b*4 +: 4]     = Skew ? 4'((b + c) % B) : 4'(b);
    end
    r.cc = 12'(c);
    return r;
  endfunction

  task automatic compare_chunk(input string name, input chunk_t exp);
    for (int b = 0; b < B; b++) begin
      check($sformatf("%s_bank%0d", name, b), data_out[b*64 +: 64], exp.data[b*64 +: 64]);
    end
    check({name, "_bank_num"}, bank_num, exp.bn);
    check({name, "_cycle_count"}, 64'(cycle_count), 64'(exp.cc));
  endtask

  task automatic check_zero(input string name);
    check({name, "_in_ready"}, 64'(in_ready), 64'd0);
    check({name, "_fft_enable"}, 64'(fft_enable), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    for (int b = 0; b < B; b++) begin
      check($sformatf("%s_data%0d", name, b), data_out[b*64 +: 64], 64'd0);
    end
    check({name, "_bank_num"}, bank_num, 64'd0);
    check({name, "_cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  // Monitor: pop on every presented chunk, otherwise outputs must hold the last chunk.
  initial begin
    last_exp.data = '0;
    last_exp.bn   = '0;
    last_exp.cc   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        last_exp.data = '0;
        last_exp.bn   = '0;
        last_exp.cc   = '0;
      end else begin
        if (fft_enable) begin
          fe_cnt++;
          if (sb.size() == 0) begin
            check("unexpected_fft_enable", 64'(fft_enable), 64'd0);
          end else begin
            last_exp = sb.pop_front();
            compare_chunk("chunk", last_exp);
          end
        end else begin
          compare_chunk("hold", last_exp);
        end
        if (done) begin
          done_cnt++;
          check("done_cycle_count", 64'(cycle_count), 64'(D - 1));
          check("done_fft_enable", 64'(fft_enable), 64'd1);
        end
      end
    end
  end

  // Stall driver: 0 none, 1 random, 2 three cycles while c = 5.
  initial begin
    stall = 1'b0;
    forever begin
      @(negedge clk);
      case (stall_mode)
        1: stall = ($urandom_range(3) == 0);
        2: begin
          stall = 1'b0;
          if (!stall_fired && rst_n && fft_enable && cycle_count == 12'd4) begin
            stall_fired = 1'b1;
            stall = 1'b1;
            repeat (3) begin
              @(negedge clk);
              check("stall_fft_enable", 64'(fft_enable), 64'd0);
            end
            stall = 1'b0;
          end
        end
        default: stall = 1'b0;
      endcase
    end
  end

  // Entered #1 after a rising edge with the DUT in IDLE.
  task automatic run_block(input bit ramp, input bit gaps, input int smode, input bit abort);
    int i;
    int cyc;
    int k;
    bit acc;
    for (int w = 0; w < N; w++) words[w] = ramp ? 64'(w) : {$urandom, $urandom};
    stall_mode  = smode;
    stall_fired = 1'b0;
    fe_cnt      = 0;
    done_cnt    = 0;
    for (int c = 0; c < D; c++) sb.push_back(model(c));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    i   = 0;
    cyc = 0;
    while (i < N && cyc < 3 * N) begin
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      in_data  = words[i];
      if (gaps) start = $urandom_range(1);
      @(negedge clk);
      if (cyc == 0) check("in_ready_after_start", 64'(in_ready), 64'd1);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("words_accepted", 64'(i), 64'(N));
    check("load_cycles", 64'(cyc), gaps ? 64'(2 * N - 1) : 64'(N));
    k = 0;
    while (k < 4 * D) begin
      @(negedge clk);
      if (abort && fft_enable && cycle_count == 12'd9) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midread_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      if (done) break;
      k++;
    end
    if (k == 4 * D) check("done_timeout", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    check("fft_enable_count", 64'(fe_cnt), 64'(D));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_block(1'b1, 1'b0, 0, 1'b0);  // ramp data, no gaps
    run_block(1'b0, 1'b1, 2, 1'b0);  // gapped load, stall at c = 5
    run_block(1'b0, 1'b0, 1, 1'b0);  // back-to-back start, random stalls
    run_block(1'b0, 1'b0, 0, 1'b1);  // reset during READ
    run_block(1'b1, 1'b0, 1, 1'b0);  // reload after reset
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
